// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART transmitter.
// Define UART_ARB_TAG_EN to send a tag byte before each message.
module uart_tx_arbiter #(
  parameter int          NREQ     = 4,
  parameter logic [7:0]  TAG_BASE = 8'h30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              tx_send,
  output logic [7:0]        tx_byte,
  input  logic              tx_done
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {
    S_IDLE, S_TAG, S_LOAD, S_WAIT
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_WAIT
  } state_e;
  logic unused_tag;
  assign unused_tag = ^TAG_BASE;
`endif

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            send_q, send_d;
  logic [7:0]      byte_q, byte_d;
  logic            busy_q, busy_d;

  logic            sel_req;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic [NREQ-1:0] sel_oh;
  logic            win_ok;
  logic [2:0]      win_id;
  logic [3:0]      idx;

  // Holder's request lines and the next round-robin winner after ptr.
  always_comb begin
    sel_req  = 1'b0;
    sel_data = 8'h00;
    sel_last = 1'b0;
    sel_oh   = '0;
    win_ok   = 1'b0;
    win_id   = 3'd0;
    idx      = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_req   = req[i];
        sel_data  = req_data[8*i +: 8];
        sel_last  = req_last[i];
        sel_oh[i] = 1'b1;
      end
    end
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NREQ)) begin
        idx = idx - 4'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (idx == 4'(j) && req[j]) begin
          win_ok = 1'b1;
          win_id = 3'(j);
        end
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    last_d  = last_q;
    byte_d  = byte_q;
    ack_d   = '0;
    send_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_ok) begin
          grant_d = win_id;
`ifdef UART_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        byte_d  = TAG_BASE + {5'd0, grant_q};
        send_d  = 1'b1;
        last_d  = 1'b0;
        state_d = S_WAIT;
      end
`endif
      S_LOAD: begin
        if (sel_req) begin
          byte_d  = sel_data;
          send_d  = 1'b1;
          ack_d   = sel_oh;
          last_d  = sel_last;
          state_d = S_WAIT;
        end else begin
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            ptr_d   = grant_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'(NREQ-1);
      grant_q <= 3'd0;
      last_q  <= 1'b0;
      ack_q   <= '0;
      send_q  <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign tx_send  = send_q;
  assign tx_byte  = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a message-level model.
// Requesters and the transmitter are modelled as queues and a delay.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DLY  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   ack;
  logic [2:0]        grant_id;
  logic              busy;
  logic              tx_send;
  logic [7:0]        tx_byte;
  logic              tx_done = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [8:0] rq [NREQ][$];
  int         ackcnt [NREQ];
  int         tx_cnt = 0;
  logic [7:0] lb[$];
  int         lg[$];
  logic [7:0] eb[$];
  int         eg[$];

  // model state
  int              m_hold = -1;
  int              m_ptr = NREQ-1;
  bit              m_load = 0, m_tag = 0, m_fly = 0, m_last = 0;
  logic            exp_send = 1'b0;
  logic [NREQ-1:0] exp_ack = '0;
  logic [7:0]      exp_byte = 8'h00;
  logic [2:0]      exp_gid = 3'd0;
  logic            exp_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TAG_BASE(8'h30)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .ack(ack), .grant_id(grant_id),
    .busy(busy), .tx_send(tx_send), .tx_byte(tx_byte),
    .tx_done(tx_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic void drive_reqs();
    logic [8:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endfunction

  function automatic bit qempty();
    for (int i = 0; i < NREQ; i++)
      if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // requesters and transmitter, acting just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_cnt = 0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) begin
          ackcnt[i]++;
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
      if (tx_send) begin
        lb.push_back(tx_byte);
        lg.push_back(int'(grant_id));
        chk("one_outstanding", tx_cnt, 0);
        tx_cnt = DLY;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
    end
    drive_reqs();
  end

  // message-level model of the arbiter
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_hold = -1; m_ptr = NREQ-1;
      m_load = 0; m_tag = 0; m_fly = 0; m_last = 0;
      exp_send = 1'b0; exp_ack = '0; exp_byte = 8'h00;
      exp_gid = 3'd0; exp_busy = 1'b0;
    end else begin
      exp_send = 1'b0;
      exp_ack = '0;
      if (m_tag) begin
        m_tag = 0;
        exp_send = 1'b1;
        exp_byte = 8'h30 + 8'(m_hold);
        m_last = 0;
        m_fly = 1;
      end else if (m_load) begin
        m_load = 0;
        if (req[m_hold]) begin
          exp_send = 1'b1;
          exp_byte = req_data[8*m_hold +: 8];
          exp_ack[m_hold] = 1'b1;
          m_last = req_last[m_hold];
          m_fly = 1;
        end else begin
          m_ptr = m_hold;
          m_hold = -1;
        end
      end else if (m_fly) begin
        if (tx_done) begin
          m_fly = 0;
          if (m_last) begin
            m_ptr = m_hold;
            m_hold = -1;
          end else begin
            m_load = 1;
          end
        end
      end else if (m_hold < 0 && |req) begin
        m_hold = rr(m_ptr, req);
        exp_gid = 3'(m_hold);
`ifdef UART_ARB_TAG_EN
        m_tag = 1;
`else
        m_load = 1;
`endif
      end
      exp_busy = (m_hold >= 0);
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("tx_send", 32'(tx_send), 32'(exp_send));
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("tx_byte", 32'(tx_byte), 32'(exp_byte));
    end
  end

  task automatic push(input int i, input bit last, input logic [7:0] b);
    rq[i].push_back({last, b});
  endtask

  task automatic ex(input int g, input logic [7:0] b, input bit first);
`ifdef UART_ARB_TAG_EN
    if (first) begin
      eb.push_back(8'h30 + 8'(g));
      eg.push_back(g);
    end
`else
    if (first) begin end
`endif
    eb.push_back(b);
    eg.push_back(g);
  endtask

  task automatic clr();
    lb.delete(); lg.delete(); eb.delete(); eg.delete();
    for (int i = 0; i < NREQ; i++) ackcnt[i] = 0;
  endtask

  task automatic wait_quiet(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk);
      if (k > 3 && !busy && tx_cnt == 0 && qempty()) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_quiet actual=timeout required=idle", nm);
    end
  endtask

  task automatic wait_ack(input int i, input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (ackcnt[i] >= n) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_ack actual=%0d required=%0d", nm, ackcnt[i], n);
    end
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, lb.size(), eb.size());
    for (int i = 0; i < eb.size() && i < lb.size(); i++) begin
      chk({nm, "_byte"}, 32'(lb[i]), 32'(eb[i]));
      chk({nm, "_gid"}, lg[i], eg[i]);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_ack"}, 32'(ack), 0);
    chk({nm, "_send"}, 32'(tx_send), 0);
    chk({nm, "_byte"}, 32'(tx_byte), 0);
    chk({nm, "_gid"}, 32'(grant_id), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;

    // single requester, two-byte message
    clr();
    push(0, 0, 8'h41); push(0, 1, 8'h42);
    ex(0, 8'h41, 1); ex(0, 8'h42, 0);
    wait_quiet("t1");
    chk_log("t1");
    chk("t1_acks", ackcnt[0], 2);

    // two requesters from reset alternate 0,2,0,2
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    clr();
    push(0, 1, 8'hA0); push(0, 1, 8'hA1);
    push(2, 1, 8'hC0); push(2, 1, 8'hC1);
    ex(0, 8'hA0, 1); ex(2, 8'hC0, 1);
    ex(0, 8'hA1, 1); ex(2, 8'hC1, 1);
    wait_quiet("t2");
    chk_log("t2");

    // no pre-emption of a three-byte message
    clr();
    push(1, 0, 8'hB0); push(1, 0, 8'hB1); push(1, 1, 8'hB2);
    ex(1, 8'hB0, 1); ex(1, 8'hB1, 0); ex(1, 8'hB2, 0);
    wait_ack(1, 1, "t3");
    push(3, 1, 8'hD0);
    ex(3, 8'hD0, 1);
    wait_quiet("t3");
    chk_log("t3");
    chk("t3_acks3", ackcnt[3], 1);

    // abort: requester 0 drops mid-message, ptr lands on 0
    clr();
    push(1, 1, 8'hF0);
    ex(1, 8'hF0, 1);
    wait_quiet("t4a");
    push(0, 0, 8'hE0);
    ex(0, 8'hE0, 1);
    wait_ack(0, 1, "t4");
    push(1, 1, 8'hF1); push(2, 1, 8'hF2);
    ex(1, 8'hF1, 1); ex(2, 8'hF2, 1);
    wait_quiet("t4");
    chk_log("t4");

    // spurious tx_done in IDLE and in LOAD
    clr();
    tx_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_sends", lb.size(), 0);
    push(3, 1, 8'h99);
    ex(3, 8'h99, 1);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (busy) seen = 1'b1;
      end
      chk("t5_busy_rise", 32'(seen), 1);
    end
    tx_done = 1'b1;
    wait_quiet("t5");
    chk_log("t5");
    chk("t5_acks3", ackcnt[3], 1);

    // asynchronous reset while waiting for tx_done
    clr();
    push(2, 0, 8'h77); push(2, 1, 8'h78);
    wait_ack(2, 1, "t6");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    push(0, 1, 8'h10); push(1, 1, 8'h11);
    ex(0, 8'h10, 1); ex(1, 8'h11, 1);
    wait_quiet("t6");
    chk_log("t6");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one 8N1 UART transmitter among up to 8 byte-stream requesters. It issues the transmitter's one-cycle send pulse and byte, waits for its done pulse, and holds the grant for a whole message (up to a byte flagged last). It sits between the UART transmitter and the on-chip producers (debug printer, sensor reporter, etc.).

## Interface
- NREQ, 4, number of requesters (2..8)
- TAG_BASE, 8'h30, tag byte base; tag = TAG_BASE + requester index (tag build only)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  requester i has a byte pending; level, held until acked
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NREQ  byte of requester i ends its message
- ack  out  NREQ  one-cycle pulse: byte of requester i taken; requester presents next byte or drops req
- grant_id  out  3  index of current/last grant holder
- busy  out  1  high in every state except IDLE
- tx_send  out  1  one-cycle send pulse to the transmitter's senddata
- tx_byte  out  8  byte to the transmitter's txbyte, valid while tx_send is high and held after
- tx_done  in  1  one-cycle done pulse from the transmitter (stop bit started)

## Operation
- States: IDLE, TAG (tag build only), LOAD, WAIT.
- IDLE: if any req, winner = first set bit searching from ptr+1 upward modulo NREQ; register grant_id; go TAG (tag build) or LOAD.
- TAG: tx_byte <= TAG_BASE + grant_id, tx_send pulse, last_flag <= 0, no ack; go WAIT.
- LOAD: if req[grant_id]: tx_byte <= req_data[grant_id], tx_send pulse, ack[grant_id] pulse, last_flag <= req_last[grant_id]; go WAIT. If req[grant_id] low: message aborted, ptr <= grant_id; go IDLE.
- WAIT: on tx_done: if last_flag, ptr <= grant_id and go IDLE; else go LOAD. Other inputs ignored.
- Grant is never pre-empted mid-message; other requesters wait until last byte done or abort.
- tx_done in any state other than WAIT is ignored.
- At most one tx_send between consecutive tx_done pulses; never two sends outstanding.
- Requests outside 0..NREQ-1 do not exist; unused grant_id bits are zero.

## Timing
- Reset values: state IDLE, ack 0, tx_send 0, tx_byte 8'h00, grant_id 0, busy 0, ptr NREQ-1 (requester 0 wins first), last_flag 0.
- All outputs are registered.
- req sampled in IDLE at edge N -> grant_id valid after N; tx_send and ack (or tag tx_send) high for the cycle after edge N+1.
- tx_done sampled at edge M in WAIT -> next byte's tx_send high after edge M+1 (LOAD), i.e. 2 cycles done-to-send; last byte -> IDLE after M, new arbitration at M+1.
- Requester must update req_data/req_last/req within the cycle after ack; sampled again no earlier than the next LOAD.
- Simultaneous req from several requesters: only round-robin winner acked; losers keep req high.
- rst_n asserted mid-frame: block returns to IDLE immediately; the transmitter completes its frame. rst_n must stay low for at least one frame time, or the transmitter must be reset by the same source.

## Configuration
- UART_ARB_TAG_EN defined: on each new grant one tag byte (TAG_BASE + grant_id) is sent before the first data byte; abort after tag sends no further bytes.
- Undefined: TAG state absent, IDLE goes directly to LOAD, stream contains data bytes only.

## Test plan
- Single requester 0, bytes 8'h41,8'h42 (last on 8'h42), tx_done 20 cycles after each send -> tx_byte 41 then 42, two ack pulses, busy low 1 cycle after second tx_done; with tag build stream is 30,41,42.
- req 0 and 2 both high with 1-byte messages from reset -> order 0,2,0,2; grant_id follows; no back-to-back tx_send without intervening tx_done.
- Requester 1 sends 3-byte message while requester 3 requests after byte 1 -> requester 3 acked only after requester 1's last tx_done.
- Requester 0 drops req after first ack (no last) -> after tx_done, block returns to IDLE, ptr=0, requester 1 wins next.
- Spurious tx_done in IDLE and LOAD -> no state change, no tx_send.
- rst_n low during WAIT -> all outputs reset values asynchronously; after release requester 0 wins first.
